idli_ex_slice_m: RTL and testbench

//  Parametrised bit-serial execution sequencer. Runs one WORD_W-bit ALU op as

---
 rtl/idli_ex_slice_m_if.sv | 43 ++++
 rtl/idli_ex_slice_m.sv | 151 +++++++++++++++
 tb/tb_idli_ex_slice_m.sv | 395 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/idli_ex_slice_m_if.sv
// Handshake and slice-data bundle between decode, the execution sequencer
// and the register/predicate files.
interface idli_ex_slice_m_if #(
    parameter int SLICE_W = 4,
    parameter int WORD_W  = 16
);
    localparam int CTR_W = $clog2(WORD_W / SLICE_W);

    logic               i_ex_op_vld;
    logic               o_ex_op_acp;
    logic [1:0]         i_ex_alu_op;
    logic               i_ex_rhs_inv;
    logic               i_ex_cin;
    logic               i_ex_set_flags;
    logic               i_ex_cmp;
    logic [2:0]         i_ex_cond;
    logic               i_ex_stall;
    logic               i_ex_flush;
    logic [SLICE_W-1:0] i_ex_lhs;
    logic [SLICE_W-1:0] i_ex_rhs;
    logic               o_ex_busy;
    logic [CTR_W-1:0]   o_ex_ctr;
    logic [SLICE_W-1:0] o_ex_out;
    logic               o_ex_out_vld;
    logic               o_ex_done;
    logic               o_ex_pred_wr_en;
    logic               o_ex_pred_data;
    logic [3:0]         o_ex_flags;

    modport slave (
        input  i_ex_op_vld, i_ex_alu_op, i_ex_rhs_inv, i_ex_cin, i_ex_set_flags,
               i_ex_cmp, i_ex_cond, i_ex_stall, i_ex_flush, i_ex_lhs, i_ex_rhs,
        output o_ex_op_acp, o_ex_busy, o_ex_ctr, o_ex_out, o_ex_out_vld,
               o_ex_done, o_ex_pred_wr_en, o_ex_pred_data, o_ex_flags
    );

    modport master (
        output i_ex_op_vld, i_ex_alu_op, i_ex_rhs_inv, i_ex_cin, i_ex_set_flags,
               i_ex_cmp, i_ex_cond, i_ex_stall, i_ex_flush, i_ex_lhs, i_ex_rhs,
        input  o_ex_op_acp, o_ex_busy, o_ex_ctr, o_ex_out, o_ex_out_vld,
               o_ex_done, o_ex_pred_wr_en, o_ex_pred_data, o_ex_flags
    );
endinterface

// File: rtl/idli_ex_slice_m.sv
// Bit-serial execution sequencer: one WORD_W-bit ALU op run as WORD_W/SLICE_W
// slices, LSB first, with carry chain, ZNCV accumulation and predicate eval.
//
// state   | meaning
// ST_IDLE | no op in flight, ready to accept
// ST_RUN  | op in flight, o_ex_ctr selects the slice being processed
module idli_ex_slice_m #(
    parameter int SLICE_W = 4,
    parameter int WORD_W  = 16
) (
    input logic            i_ex_gck,
    input logic            i_ex_rst_n,
    idli_ex_slice_m_if.slave ex_if
);
    localparam int CYCLES = WORD_W / SLICE_W;
    localparam int CTR_W  = $clog2(CYCLES);
    localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(CYCLES - 1);

    typedef enum logic {ST_IDLE, ST_RUN} state_e;

    state_e             state_q, state_d;
    logic [CTR_W-1:0]   ctr_q, ctr_d;
    logic               carry_q, carry_d;
    logic               zacc_q, zacc_d;
    logic [3:0]         flags_q, flags_d;
    logic [1:0]         alu_op_q, alu_op_d;
    logic               rhs_inv_q, rhs_inv_d;
    logic               cin_q, cin_d;
    logic               set_flags_q, set_flags_d;
    logic               cmp_q, cmp_d;
    logic [2:0]         cond_q, cond_d;

    logic               busy, run, last, done, acp, accept;
    logic [SLICE_W-1:0] rhs_eff, out;
    logic [SLICE_W:0]   sum;
    logic               cin_k, is_add, c_msb, c_out, v_out, pred;
    logic [3:0]         flags_new;

    always_comb begin
        rhs_eff   = rhs_inv_q ? ~ex_if.i_ex_rhs : ex_if.i_ex_rhs;
        cin_k     = (ctr_q == '0) ? cin_q : carry_q;
        sum       = {1'b0, ex_if.i_ex_lhs} + {1'b0, rhs_eff} + {{SLICE_W{1'b0}}, cin_k};
        // Carry into the MSB recovered from the MSB sum bit and its operands.
        c_msb     = ex_if.i_ex_lhs[SLICE_W-1] ^ rhs_eff[SLICE_W-1] ^ sum[SLICE_W-1];
        is_add    = (alu_op_q == 2'd0);
        case (alu_op_q)
            2'd0:    out = sum[SLICE_W-1:0];
            2'd1:    out = ex_if.i_ex_lhs & rhs_eff;
            2'd2:    out = ex_if.i_ex_lhs | rhs_eff;
            default: out = ex_if.i_ex_lhs ^ rhs_eff;
        endcase
        c_out     = is_add & sum[SLICE_W];
        v_out     = is_add & (c_msb ^ sum[SLICE_W]);
        flags_new = {zacc_q && (out == '0), out[SLICE_W-1], c_out, v_out};
        case (cond_q)
            3'd0:    pred = flags_new[3];
            3'd1:    pred = !flags_new[3];
            3'd2:    pred = flags_new[2] ^ flags_new[0];
            3'd3:    pred = !(flags_new[2] ^ flags_new[0]);
            3'd4:    pred = !flags_new[1];
            3'd5:    pred = flags_new[1];
            3'd6:    pred = flags_new[2];
            default: pred = 1'b1;
        endcase
    end

    always_comb begin
        busy   = (state_q == ST_RUN);
        run    = busy && !ex_if.i_ex_stall && !ex_if.i_ex_flush;
        last   = (ctr_q == CTR_LAST);
        done   = run && last;
        acp    = (!busy || done) && !ex_if.i_ex_flush;
        accept = ex_if.i_ex_op_vld && acp;
    end

    always_comb begin
        state_d     = state_q;
        ctr_d       = ctr_q;
        carry_d     = carry_q;
        zacc_d      = zacc_q;
        flags_d     = flags_q;
        alu_op_d    = alu_op_q;
        rhs_inv_d   = rhs_inv_q;
        cin_d       = cin_q;
        set_flags_d = set_flags_q;
        cmp_d       = cmp_q;
        cond_d      = cond_q;
        if (run) begin
            carry_d = c_out;
            zacc_d  = flags_new[3];
            ctr_d   = last ? '0 : ctr_q + CTR_W'(1);
            if (last) begin
                state_d = ST_IDLE;
                if (set_flags_q) flags_d = flags_new;
            end
        end
        // An accept on the done edge overrides the return to idle.
        if (ex_if.i_ex_flush) begin
            state_d = ST_IDLE;
            ctr_d   = '0;
        end else if (accept) begin
            state_d     = ST_RUN;
            ctr_d       = '0;
            zacc_d      = 1'b1;
            alu_op_d    = ex_if.i_ex_alu_op;
            rhs_inv_d   = ex_if.i_ex_rhs_inv;
            cin_d       = ex_if.i_ex_cin;
            set_flags_d = ex_if.i_ex_set_flags;
            cmp_d       = ex_if.i_ex_cmp;
            cond_d      = ex_if.i_ex_cond;
        end
    end

    always_ff @(posedge i_ex_gck or negedge i_ex_rst_n) begin
        if (!i_ex_rst_n) begin
            state_q     <= ST_IDLE;
            ctr_q       <= '0;
            carry_q     <= 1'b0;
            zacc_q      <= 1'b1;
            flags_q     <= 4'b1000;
            alu_op_q    <= 2'd0;
            rhs_inv_q   <= 1'b0;
            cin_q       <= 1'b0;
            set_flags_q <= 1'b0;
            cmp_q       <= 1'b0;
            cond_q      <= 3'd0;
        end else begin
            state_q     <= state_d;
            ctr_q       <= ctr_d;
            carry_q     <= carry_d;
            zacc_q      <= zacc_d;
            flags_q     <= flags_d;
            alu_op_q    <= alu_op_d;
            rhs_inv_q   <= rhs_inv_d;
            cin_q       <= cin_d;
            set_flags_q <= set_flags_d;
            cmp_q       <= cmp_d;
            cond_q      <= cond_d;
        end
    end

    assign ex_if.o_ex_op_acp     = acp;
    assign ex_if.o_ex_busy       = busy;
    assign ex_if.o_ex_ctr        = ctr_q;
    assign ex_if.o_ex_out        = out;
    assign ex_if.o_ex_out_vld    = run;
    assign ex_if.o_ex_done       = done;
    assign ex_if.o_ex_pred_wr_en = done && cmp_q;
    assign ex_if.o_ex_pred_data  = pred;
    assign ex_if.o_ex_flags      = flags_q;
endmodule

// File: tb/tb_idli_ex_slice_m.sv
// Bench for idli_ex_slice_m: directed scenarios plus randomized ops checked
// against a whole-word arithmetic reference model.
module tb_idli_ex_slice_m;
    localparam int S  = 4;
    localparam int W  = 16;
    localparam int NC = W / S;

    typedef struct {
        logic [1:0]   alu;
        logic         inv;
        logic         cin;
        logic         setf;
        logic         cmp;
        logic [2:0]   cond;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } op_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst_w_n = 1'b0;
    always #5 clk = ~clk;

    idli_ex_slice_m_if #(.SLICE_W(4), .WORD_W(16)) d_if ();
    idli_ex_slice_m_if #(.SLICE_W(8), .WORD_W(32)) w_if ();

    idli_ex_slice_m #(.SLICE_W(4), .WORD_W(16)) u_dut (
        .i_ex_gck   (clk),
        .i_ex_rst_n (rst_n),
        .ex_if      (d_if)
    );

    idli_ex_slice_m #(.SLICE_W(8), .WORD_W(32)) u_wide (
        .i_ex_gck   (clk),
        .i_ex_rst_n (rst_w_n),
        .ex_if      (w_if)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [3:0] exp_flags;

    // Reference: whole-word result, flags {Z,N,C,V}, condition evaluation.
    function automatic logic [W:0] ref_sum(op_t op);
        logic [W-1:0] bb;
        bb = op.inv ? ~op.b : op.b;
        case (op.alu)
            2'd0:    return {1'b0, op.a} + {1'b0, bb} + (W+1)'(op.cin);
            2'd1:    return {1'b0, op.a & bb};
            2'd2:    return {1'b0, op.a | bb};
            default: return {1'b0, op.a ^ bb};
        endcase
    endfunction

    function automatic logic [3:0] ref_flags(op_t op);
        logic [W:0]   r;
        logic [W-1:0] res, bb;
        logic         c, v;
        r   = ref_sum(op);
        res = r[W-1:0];
        bb  = op.inv ? ~op.b : op.b;
        c   = 1'b0;
        v   = 1'b0;
        if (op.alu == 2'd0) begin
            c = r[W];
            v = (op.a[W-1] == bb[W-1]) && (res[W-1] != op.a[W-1]);
        end
        return {res == '0, res[W-1], c, v};
    endfunction

    function automatic logic ref_pred(logic [3:0] f, logic [2:0] cond);
        logic z, n, c, v;
        {z, n, c, v} = f;
        case (cond)
            3'd0: return z;
            3'd1: return !z;
            3'd2: return n ^ v;
            3'd3: return !(n ^ v);
            3'd4: return !c;
            3'd5: return c;
            3'd6: return n;
            default: return 1'b1;
        endcase
    endfunction

    task automatic drive_fields(op_t op);
        d_if.i_ex_alu_op    = op.alu;
        d_if.i_ex_rhs_inv   = op.inv;
        d_if.i_ex_cin       = op.cin;
        d_if.i_ex_set_flags = op.setf;
        d_if.i_ex_cmp       = op.cmp;
        d_if.i_ex_cond      = op.cond;
    endtask

    task automatic offer(op_t op);
        drive_fields(op);
        d_if.i_ex_op_vld = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (d_if.o_ex_op_acp !== 1'b1 || d_if.o_ex_busy !== 1'b0) begin
            n_err++;
            $display("FAIL offer: acp=%b busy=%b, want acp=1 busy=0", d_if.o_ex_op_acp, d_if.o_ex_busy);
        end
        @(posedge clk); #1;
        d_if.i_ex_op_vld = 1'b0;
    endtask

    task automatic run_slices(op_t op, int stall_ctr, int stall_len, int flush_ctr,
                              bit has_next, op_t nxt);
        logic [W:0]   r;
        logic [W-1:0] res;
        logic [3:0]   fl;
        logic         pd;
        logic         lst;
        r   = ref_sum(op);
        res = r[W-1:0];
        fl  = ref_flags(op);
        pd  = ref_pred(fl, op.cond);
        for (int k = 0; k < NC; k++) begin
            lst = (k == NC - 1);
            d_if.i_ex_lhs = op.a[k*S +: S];
            d_if.i_ex_rhs = op.b[k*S +: S];
            if (k == stall_ctr) begin
                for (int s = 0; s < stall_len; s++) begin
                    d_if.i_ex_stall = 1'b1;
                    d_if.i_ex_op_vld = 1'b1;
                    @(negedge clk);
                    n_cmp++;
                    if (d_if.o_ex_out_vld !== 1'b0 || d_if.o_ex_done !== 1'b0 ||
                        d_if.o_ex_ctr !== k[1:0] || d_if.o_ex_op_acp !== 1'b0 ||
                        d_if.o_ex_pred_wr_en !== 1'b0) begin
                        n_err++;
                        $display("FAIL stall k=%0d: out_vld=%b done=%b ctr=%0d acp=%b pwr=%b, want 0 0 %0d 0 0",
                                 k, d_if.o_ex_out_vld, d_if.o_ex_done, d_if.o_ex_ctr,
                                 d_if.o_ex_op_acp, d_if.o_ex_pred_wr_en, k);
                    end
                    @(posedge clk); #1;
                end
                d_if.i_ex_stall  = 1'b0;
                d_if.i_ex_op_vld = 1'b0;
            end
            if (k == flush_ctr) begin
                d_if.i_ex_flush  = 1'b1;
                d_if.i_ex_stall  = 1'($urandom_range(0, 1));
                d_if.i_ex_op_vld = 1'b1;
                @(negedge clk);
                n_cmp++;
                if (d_if.o_ex_out_vld !== 1'b0 || d_if.o_ex_done !== 1'b0 ||
                    d_if.o_ex_pred_wr_en !== 1'b0 || d_if.o_ex_op_acp !== 1'b0) begin
                    n_err++;
                    $display("FAIL flush_cycle k=%0d: out_vld=%b done=%b pwr=%b acp=%b, want all 0",
                             k, d_if.o_ex_out_vld, d_if.o_ex_done, d_if.o_ex_pred_wr_en, d_if.o_ex_op_acp);
                end
                @(posedge clk); #1;
                d_if.i_ex_flush  = 1'b0;
                d_if.i_ex_stall  = 1'b0;
                d_if.i_ex_op_vld = 1'b0;
                @(negedge clk);
                n_cmp++;
                if (d_if.o_ex_busy !== 1'b0 || d_if.o_ex_ctr !== 2'd0 ||
                    d_if.o_ex_op_acp !== 1'b1 || d_if.o_ex_flags !== exp_flags) begin
                    n_err++;
                    $display("FAIL flush_after: busy=%b ctr=%0d acp=%b flags=%b, want 0 0 1 %b",
                             d_if.o_ex_busy, d_if.o_ex_ctr, d_if.o_ex_op_acp, d_if.o_ex_flags, exp_flags);
                end
                @(posedge clk); #1;
                return;
            end
            if (lst && has_next) begin
                drive_fields(nxt);
                d_if.i_ex_op_vld = 1'b1;
            end
            @(negedge clk);
            n_cmp++;
            if (d_if.o_ex_ctr !== k[1:0] || d_if.o_ex_out_vld !== 1'b1 ||
                d_if.o_ex_out !== res[k*S +: S] || d_if.o_ex_done !== lst ||
                d_if.o_ex_op_acp !== lst || d_if.o_ex_pred_wr_en !== (lst && op.cmp)) begin
                n_err++;
                $display("FAIL slice k=%0d: ctr=%0d vld=%b out=%h done=%b acp=%b pwr=%b, want %0d 1 %h %b %b %b",
                         k, d_if.o_ex_ctr, d_if.o_ex_out_vld, d_if.o_ex_out, d_if.o_ex_done,
                         d_if.o_ex_op_acp, d_if.o_ex_pred_wr_en,
                         k, res[k*S +: S], lst, lst, lst && op.cmp);
            end
            if (lst && op.cmp) begin
                n_cmp++;
                if (d_if.o_ex_pred_data !== pd) begin
                    n_err++;
                    $display("FAIL pred cond=%0d: got %b want %b", op.cond, d_if.o_ex_pred_data, pd);
                end
            end
            @(posedge clk); #1;
            if (lst && has_next) d_if.i_ex_op_vld = 1'b0;
        end
        if (op.setf) exp_flags = fl;
        if (!has_next) begin
            @(negedge clk);
            n_cmp++;
            if (d_if.o_ex_flags !== exp_flags || d_if.o_ex_busy !== 1'b0) begin
                n_err++;
                $display("FAIL flags_end: flags=%b busy=%b, want %b 0", d_if.o_ex_flags, d_if.o_ex_busy, exp_flags);
            end
            @(posedge clk); #1;
        end
    endtask

    function automatic op_t mk_op(logic [1:0] alu, logic inv, logic cin, logic setf,
                                  logic cmp, logic [2:0] cond, logic [W-1:0] a, logic [W-1:0] b);
        op_t o;
        o.alu = alu; o.inv = inv; o.cin = cin; o.setf = setf;
        o.cmp = cmp; o.cond = cond; o.a = a; o.b = b;
        return o;
    endfunction

    task automatic test_reset();
        op_t z;
        z = mk_op(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, '0, '0);
        drive_fields(z);
        d_if.i_ex_op_vld = 1'b0; d_if.i_ex_stall = 1'b0; d_if.i_ex_flush = 1'b0;
        d_if.i_ex_lhs = '0; d_if.i_ex_rhs = '0;
        w_if.i_ex_op_vld = 1'b0; w_if.i_ex_alu_op = 2'd0; w_if.i_ex_rhs_inv = 1'b0;
        w_if.i_ex_cin = 1'b0; w_if.i_ex_set_flags = 1'b0; w_if.i_ex_cmp = 1'b0;
        w_if.i_ex_cond = 3'd0; w_if.i_ex_stall = 1'b0; w_if.i_ex_flush = 1'b0;
        w_if.i_ex_lhs = '0; w_if.i_ex_rhs = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (d_if.o_ex_busy !== 1'b0 || d_if.o_ex_ctr !== 2'd0 || d_if.o_ex_flags !== 4'b1000 ||
            d_if.o_ex_out_vld !== 1'b0 || d_if.o_ex_done !== 1'b0 ||
            d_if.o_ex_pred_wr_en !== 1'b0 || d_if.o_ex_op_acp !== 1'b1) begin
            n_err++;
            $display("FAIL reset: busy=%b ctr=%0d flags=%b vld=%b done=%b pwr=%b acp=%b, want 0 0 1000 0 0 0 1",
                     d_if.o_ex_busy, d_if.o_ex_ctr, d_if.o_ex_flags, d_if.o_ex_out_vld,
                     d_if.o_ex_done, d_if.o_ex_pred_wr_en, d_if.o_ex_op_acp);
        end
        rst_n = 1'b1;
        rst_w_n = 1'b1;
        exp_flags = 4'b1000;
        @(posedge clk); #1;
    endtask

    task automatic test_add_overflow();
        op_t o;
        o = mk_op(2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 16'h7FFF, 16'h0001);
        offer(o);
        run_slices(o, -1, 0, -1, 1'b0, o);
        n_cmp++;
        if (exp_flags !== 4'b0101 || d_if.o_ex_flags !== 4'b0101) begin
            n_err++;
            $display("FAIL add_ovf_flags: got %b want 0101", d_if.o_ex_flags);
        end
    endtask

    task automatic test_sub_eq();
        op_t o;
        o = mk_op(2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 16'h0005, 16'h0005);
        offer(o);
        run_slices(o, -1, 0, -1, 1'b0, o);
        n_cmp++;
        if (d_if.o_ex_flags[3] !== 1'b1 || d_if.o_ex_flags[1] !== 1'b1) begin
            n_err++;
            $display("FAIL sub_eq_flags: got %b want Z1 C1", d_if.o_ex_flags);
        end
    endtask

    task automatic test_stall();
        op_t o;
        o = mk_op(2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd2, 16'h9AB7, 16'h6E59);
        offer(o);
        run_slices(o, 2, 3, -1, 1'b0, o);
    endtask

    task automatic test_flush();
        op_t o;
        o = mk_op(2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd7, 16'h1234, 16'h4321);
        offer(o);
        run_slices(o, -1, 0, 3, 1'b0, o);
        // Flush while idle must not accept and must leave the block idle.
        d_if.i_ex_flush = 1'b1;
        d_if.i_ex_op_vld = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (d_if.o_ex_op_acp !== 1'b0) begin
            n_err++;
            $display("FAIL idle_flush_acp: got %b want 0", d_if.o_ex_op_acp);
        end
        @(posedge clk); #1;
        d_if.i_ex_flush = 1'b0;
        d_if.i_ex_op_vld = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (d_if.o_ex_busy !== 1'b0 || d_if.o_ex_flags !== exp_flags) begin
            n_err++;
            $display("FAIL idle_flush_after: busy=%b flags=%b want 0 %b", d_if.o_ex_busy, d_if.o_ex_flags, exp_flags);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        op_t a, b;
        a = mk_op(2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 16'hFFFF, 16'h0001);
        b = mk_op(2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd4, 16'h0000, 16'h0000);
        offer(a);
        run_slices(a, -1, 0, -1, 1'b1, b);
        run_slices(b, -1, 0, -1, 1'b0, b);
    endtask

    task automatic test_random();
        op_t o;
        int  sc, sl, fc;
        for (int i = 0; i < 30; i++) begin
            o = mk_op(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                      16'($urandom), 16'($urandom));
            if (i % 5 == 0) o.b = o.a;
            sc = $urandom_range(0, 7);
            sl = $urandom_range(1, 3);
            fc = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 3) : -1;
            offer(o);
            run_slices(o, sc, sl, fc, 1'b0, o);
        end
    endtask

    task automatic test_wide();
        w_if.i_ex_alu_op = 2'd0; w_if.i_ex_rhs_inv = 1'b0; w_if.i_ex_cin = 1'b0;
        w_if.i_ex_set_flags = 1'b1; w_if.i_ex_cmp = 1'b1; w_if.i_ex_cond = 3'd0;
        w_if.i_ex_op_vld = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (w_if.o_ex_op_acp !== 1'b1) begin
            n_err++;
            $display("FAIL wide_offer: acp=%b want 1", w_if.o_ex_op_acp);
        end
        @(posedge clk); #1;
        w_if.i_ex_op_vld = 1'b0;
        for (int k = 0; k < 4; k++) begin
            w_if.i_ex_lhs = 8'hFF;
            w_if.i_ex_rhs = (k == 0) ? 8'h01 : 8'h00;
            @(negedge clk);
            n_cmp++;
            if (w_if.o_ex_out !== 8'h00 || w_if.o_ex_out_vld !== 1'b1 ||
                w_if.o_ex_ctr !== k[1:0] || w_if.o_ex_done !== (k == 3) ||
                w_if.o_ex_pred_wr_en !== (k == 3) || (k == 3 && w_if.o_ex_pred_data !== 1'b1)) begin
                n_err++;
                $display("FAIL wide_slice k=%0d: out=%h vld=%b ctr=%0d done=%b pwr=%b pd=%b",
                         k, w_if.o_ex_out, w_if.o_ex_out_vld, w_if.o_ex_ctr, w_if.o_ex_done,
                         w_if.o_ex_pred_wr_en, w_if.o_ex_pred_data);
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_cmp++;
        if (w_if.o_ex_flags !== 4'b1010) begin
            n_err++;
            $display("FAIL wide_flags: got %b want 1010", w_if.o_ex_flags);
        end
        @(posedge clk); #1;
        w_if.i_ex_op_vld = 1'b1;
        @(posedge clk); #1;
        w_if.i_ex_op_vld = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_w_n = 1'b0;
        #1;
        n_cmp++;
        if (w_if.o_ex_busy !== 1'b0 || w_if.o_ex_ctr !== 2'd0 || w_if.o_ex_flags !== 4'b1000 ||
            w_if.o_ex_out_vld !== 1'b0 || w_if.o_ex_done !== 1'b0 ||
            w_if.o_ex_pred_wr_en !== 1'b0 || w_if.o_ex_op_acp !== 1'b1) begin
            n_err++;
            $display("FAIL wide_midop_reset: busy=%b ctr=%0d flags=%b vld=%b done=%b pwr=%b acp=%b",
                     w_if.o_ex_busy, w_if.o_ex_ctr, w_if.o_ex_flags, w_if.o_ex_out_vld,
                     w_if.o_ex_done, w_if.o_ex_pred_wr_en, w_if.o_ex_op_acp);
        end
        @(posedge clk); #1;
        rst_w_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add_overflow();
        test_sub_eq();
        test_stall();
        test_flush();
        test_back_to_back();
        test_random();
        test_wide();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
